// File: rtl/val2_shift_pipe.sv
// rtl/val2_shift_pipe.sv - two-stage pipelined operand-2 generator (Val2 + shifter carry)
// S1 decodes the operand form into a mode and 9-bit amount; S2 runs the barrel shift.
module val2_shift_pipe #(
  parameter int REG_LEN = 32,
  parameter int TAG_W   = 4,
  localparam int SHAMT_W = $clog2(REG_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [REG_LEN-1:0] val_rm,
  input  logic [REG_LEN-1:0] val_rs,
  input  logic [11:0]        shift_operand,
  input  logic               immediate,
  input  logic               is_mem_command,
  input  logic               carry_in,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_LEN-1:0] val2_out,
  output logic               carry_out,
  output logic [TAG_W-1:0]   tag_out
);

  typedef enum logic [2:0] {
    M_PASS,
    M_LSL,
    M_LSR,
    M_ASR,
    M_ROR,
    M_RRX
  } mode_t;

  localparam logic [8:0]         LEN9   = 9'(REG_LEN);
  localparam logic [SHAMT_W-1:0] SH_ONE = SHAMT_W'(1);

  logic               s1_valid;
  logic               s2_valid;
  mode_t              s1_mode;
  mode_t              d_mode;
  logic [8:0]         s1_amt;
  logic [8:0]         d_amt;
  logic [REG_LEN-1:0] s1_rm;
  logic [REG_LEN-1:0] d_rm;
  logic               s1_cin;
  logic [TAG_W-1:0]   s1_tag;

  logic s2_free;
  logic s1_advance;
  logic accept;

  assign s2_free    = !s2_valid || out_ready;
  assign s1_advance = s1_valid && s2_free;
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = in_valid && in_ready;
  assign out_valid  = s2_valid;

  logic [1:0] sh_type;
  logic [4:0] imm_n;
  logic [3:0] rot;
  logic [REG_LEN-9:0] unused_rs;

  assign sh_type   = shift_operand[6:5];
  assign imm_n     = shift_operand[11:7];
  assign rot       = shift_operand[11:8];
  assign unused_rs = val_rs[REG_LEN-1:8];

  // Every operand form collapses to (mode, amount, source); the #0 aliases are resolved here.
  always_comb begin
    d_mode = M_PASS;
    d_amt  = '0;
    d_rm   = val_rm;
    if (is_mem_command) begin
      d_rm = {{(REG_LEN-12){1'b0}}, shift_operand};
    end else if (immediate) begin
      d_rm = {{(REG_LEN-8){1'b0}}, shift_operand[7:0]};
      if (rot != 4'd0) begin
        d_mode = M_ROR;
        d_amt  = {4'd0, rot, 1'b0};
      end
    end else if (!shift_operand[4]) begin
      d_amt = {4'd0, imm_n};
      case (sh_type)
        2'b00: d_mode = (imm_n == 5'd0) ? M_PASS : M_LSL;
        2'b01: begin
          d_mode = M_LSR;
          if (imm_n == 5'd0) d_amt = LEN9;
        end
        2'b10: begin
          d_mode = M_ASR;
          if (imm_n == 5'd0) d_amt = LEN9;
        end
        default: d_mode = (imm_n == 5'd0) ? M_RRX : M_ROR;
      endcase
    end else begin
      d_amt = {1'b0, val_rs[7:0]};
      if (val_rs[7:0] != 8'd0) begin
        case (sh_type)
          2'b00:   d_mode = M_LSL;
          2'b01:   d_mode = M_LSR;
          2'b10:   d_mode = M_ASR;
          default: d_mode = M_ROR;
        endcase
      end
    end
  end

  logic [SHAMT_W-1:0] sh;
  logic [SHAMT_W-1:0] lsl_idx;
  logic [SHAMT_W-1:0] rsh_idx;
  logic               amt_zero;
  logic               amt_ge;
  logic               amt_eq;
  logic [REG_LEN-1:0] ror_res;
  logic [REG_LEN-1:0] unused_ror_hi;
  logic [REG_LEN-1:0] s_res;
  logic               s_c;

  assign sh       = s1_amt[SHAMT_W-1:0];
  assign lsl_idx  = SHAMT_W'(0) - sh;
  assign rsh_idx  = sh - SH_ONE;
  assign amt_zero = (s1_amt == 9'd0);
  assign amt_ge   = (s1_amt >= LEN9);
  assign amt_eq   = (s1_amt == LEN9);
  // Rotation amount is taken mod REG_LEN by using only the low bits of the amount.
  assign {unused_ror_hi, ror_res} = {s1_rm, s1_rm} >> sh;

  always_comb begin
    s_res = s1_rm;
    s_c   = s1_cin;
    case (s1_mode)
      M_LSL: begin
        if (amt_ge) begin
          s_res = '0;
          s_c   = amt_eq ? s1_rm[0] : 1'b0;
        end else if (!amt_zero) begin
          s_res = s1_rm << sh;
          s_c   = s1_rm[lsl_idx];
        end
      end
      M_LSR: begin
        if (amt_ge) begin
          s_res = '0;
          s_c   = amt_eq ? s1_rm[REG_LEN-1] : 1'b0;
        end else if (!amt_zero) begin
          s_res = s1_rm >> sh;
          s_c   = s1_rm[rsh_idx];
        end
      end
      M_ASR: begin
        if (amt_ge) begin
          s_res = {REG_LEN{s1_rm[REG_LEN-1]}};
          s_c   = s1_rm[REG_LEN-1];
        end else if (!amt_zero) begin
          s_res = $signed(s1_rm) >>> sh;
          s_c   = s1_rm[rsh_idx];
        end
      end
      M_ROR: begin
        s_res = ror_res;
        s_c   = ror_res[REG_LEN-1];
      end
      M_RRX: begin
        s_res = {s1_cin, s1_rm[REG_LEN-1:1]};
        s_c   = s1_rm[0];
      end
      default: begin
        s_res = s1_rm;
        s_c   = s1_cin;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_mode   <= M_PASS;
      s1_amt    <= '0;
      s1_rm     <= '0;
      s1_cin    <= 1'b0;
      s1_tag    <= '0;
      val2_out  <= '0;
      carry_out <= 1'b0;
      tag_out   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_free)  s2_valid <= s1_valid;
      if (accept) begin
        s1_mode <= d_mode;
        s1_amt  <= d_amt;
        s1_rm   <= d_rm;
        s1_cin  <= carry_in;
        s1_tag  <= tag_in;
      end
      // S2 only reloads when it can move, so held results stay stable under stall.
      if (s1_advance) begin
        val2_out  <= s_res;
        carry_out <= s_c;
        tag_out   <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_val2_shift_pipe.sv
// tb/tb_val2_shift_pipe.sv - scoreboard bench for val2_shift_pipe
module tb_val2_shift_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] val_rm, val_rs;
  logic [11:0] shift_operand;
  logic        immediate, is_mem_command, carry_in;
  logic [3:0]  tag_in;
  logic        out_valid, out_ready;
  logic [31:0] val2_out;
  logic        carry_out;
  logic [3:0]  tag_out;

  val2_shift_pipe #(.REG_LEN(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .val_rm(val_rm), .val_rs(val_rs), .shift_operand(shift_operand),
    .immediate(immediate), .is_mem_command(is_mem_command), .carry_in(carry_in),
    .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .val2_out(val2_out), .carry_out(carry_out), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] v;
    logic        c;
    logic [3:0]  t;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [3:0] next_tag = 4'd0;
  bit   rand_ready = 1'b0;

  logic        s_in_ready, s_out_valid, s_c, s_acc, s_took;
  logic [31:0] s_val;
  logic [3:0]  s_tag;

  // Bit-serial reference: each step shifts one position and records the bit shifted out.
  function automatic logic [32:0] model(input logic [31:0] rm, input logic [31:0] rs,
                                        input logic [11:0] op, input logic imm,
                                        input logic mem, input logic cin);
    logic [31:0] r;
    logic        c;
    logic [1:0]  ty;
    int          n;
    r = rm;
    c = cin;
    if (mem) begin
      r = {20'd0, op};
    end else if (imm) begin
      r = {24'd0, op[7:0]};
      for (int i = 0; i < 2 * int'(op[11:8]); i++) r = {r[0], r[31:1]};
      if (op[11:8] != 4'd0) c = r[31];
    end else begin
      ty = op[6:5];
      if (!op[4]) begin
        n = int'(op[11:7]);
        if (n == 0 && (ty == 2'b01 || ty == 2'b10)) n = 32;
        if (n == 0 && ty == 2'b11) begin
          c = rm[0];
          r = {cin, rm[31:1]};
        end
      end else begin
        n = int'(rs[7:0]);
      end
      for (int i = 0; i < n; i++) begin
        case (ty)
          2'b00:   begin c = r[31]; r = r << 1; end
          2'b01:   begin c = r[0];  r = r >> 1; end
          2'b10:   begin c = r[0];  r = {r[31], r[31:1]}; end
          default: begin c = r[0];  r = {r[0], r[31:1]}; end
        endcase
      end
    end
    return {c, r};
  endfunction

  task automatic step();
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_val       = val2_out;
    s_c         = carry_out;
    s_tag       = tag_out;
    s_acc       = in_valid && in_ready && !rst && !flush;
    s_took      = out_valid && out_ready && !rst && !flush;
    if (s_took) got_q.push_back({val2_out, carry_out, tag_out});
    cyc++;
    @(negedge clk);
  endtask

  task automatic send_op(input logic [31:0] rm, input logic [31:0] rs, input logic [11:0] op,
                         input logic imm, input logic mem, input logic cin,
                         input logic [31:0] ev, input logic ec);
    val_rm = rm; val_rs = rs; shift_operand = op;
    immediate = imm; is_mem_command = mem; carry_in = cin;
    tag_in = next_tag;
    in_valid = 1'b1;
    s_acc = 1'b0;
    for (int i = 0; i < 30 && !s_acc; i++) step();
    checks++;
    if (!s_acc) begin
      errors++;
      $display("FAIL send_timeout tag %0d: accepted=0 required=1", next_tag);
    end else begin
      exp_q.push_back({ev, ec, next_tag});
      next_tag++;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] rm, input logic [31:0] rs, input logic [11:0] op,
                        input logic imm, input logic mem, input logic cin);
    logic [32:0] m;
    m = model(rm, rs, op, imm, mem, cin);
    send_op(rm, rs, op, imm, mem, cin, m[31:0], m[32]);
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < 80 && got_q.size() < n; i++) step();
    checks++;
    if (got_q.size() != n) begin
      errors++;
      $display("FAIL drain_count: got %0d results required %0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
    step(); step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    checks += 5;
    if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", s_out_valid); end
    if (s_val !== 32'd0)      begin errors++; $display("FAIL reset_val2: got %h required 0", s_val); end
    if (s_c !== 1'b0)         begin errors++; $display("FAIL reset_carry: got %b required 0", s_c); end
    if (s_tag !== 4'd0)       begin errors++; $display("FAIL reset_tag: got %h required 0", s_tag); end
    if (s_in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b required 1", s_in_ready); end
    got_q.delete();
  endtask

  task automatic test_imm_rotate();
    res_t e, g;
    out_ready = 1'b1;
    send_op(32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0, 1'b0, 32'hFF000000, 1'b1);
    send_op(32'h0, 32'h0, 12'h0AB, 1'b1, 1'b0, 1'b1, 32'h000000AB, 1'b1);
    send_op(32'h0, 32'h0, 12'h0AB, 1'b1, 1'b0, 1'b0, 32'h000000AB, 1'b0);
    send_op(32'h0, 32'h0, 12'h1FF, 1'b1, 1'b0, 1'b0, 32'hC000003F, 1'b1);
    drain(exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL imm_rotate: got v=%h c=%b t=%h required v=%h c=%b t=%h", g.v, g.c, g.t, e.v, e.c, e.t);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_imm_shift_edges();
    res_t e, g;
    out_ready = 1'b1;
    send_op(32'h80000001, 32'h0, 12'h020, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1);
    send_op(32'h80000001, 32'h0, 12'h040, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1);
    send_op(32'h80000001, 32'h0, 12'h060, 1'b0, 1'b0, 1'b1, 32'hC0000000, 1'b1);
    send_op(32'h80000001, 32'h0, 12'h080, 1'b0, 1'b0, 1'b0, 32'h00000002, 1'b1);
    send_op(32'h80000001, 32'h0, 12'h000, 1'b0, 1'b0, 1'b0, 32'h80000001, 1'b0);
    send_op(32'h80000001, 32'h0, 12'h0A0, 1'b0, 1'b0, 1'b0, 32'h40000000, 1'b1);
    send_op(32'h80000001, 32'h0, 12'h240, 1'b0, 1'b0, 1'b1, 32'hF8000000, 1'b0);
    send_op(32'h80000001, 32'h0, 12'h260, 1'b0, 1'b0, 1'b1, 32'h18000000, 1'b0);
    drain(exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL imm_shift: got v=%h c=%b t=%h required v=%h c=%b t=%h", g.v, g.c, g.t, e.v, e.c, e.t);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reg_shift();
    res_t e, g;
    logic [31:0] rs_tab [4];
    logic [31:0] ev_tab [16];
    logic        ec_tab [16];
    rs_tab = '{32'd0, 32'd32, 32'd33, 32'd64};
    ev_tab = '{32'h80000001, 32'h0, 32'h0, 32'h0,
               32'h80000001, 32'h0, 32'h0, 32'h0,
               32'h80000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'h80000001, 32'h80000001, 32'hC0000000, 32'h80000001};
    ec_tab = '{1'b0, 1'b1, 1'b0, 1'b0,
               1'b0, 1'b1, 1'b0, 1'b0,
               1'b0, 1'b1, 1'b1, 1'b1,
               1'b0, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++)
      for (int k = 0; k < 4; k++)
        send_op(32'h80000001, rs_tab[k], 12'h010 | 12'(t << 5), 1'b0, 1'b0, 1'b0,
                ev_tab[t*4+k], ec_tab[t*4+k]);
    send_op(32'h80000001, 32'h00000104, 12'h030, 1'b0, 1'b0, 1'b1, 32'h08000000, 1'b0);
    drain(exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reg_shift: got v=%h c=%b t=%h required v=%h c=%b t=%h", g.v, g.c, g.t, e.v, e.c, e.t);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_mem_mode();
    res_t e, g;
    out_ready = 1'b1;
    send_op(32'h12345678, 32'h0, 12'hFFF, 1'b1, 1'b1, 1'b1, 32'h00000FFF, 1'b1);
    send_op(32'h12345678, 32'd32, 12'h010, 1'b0, 1'b1, 1'b0, 32'h00000010, 1'b0);
    send_op(32'hFFFFFFFF, 32'h0, 12'h060, 1'b0, 1'b1, 1'b1, 32'h00000060, 1'b1);
    drain(exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL mem_mode: got v=%h c=%b t=%h required v=%h c=%b t=%h", g.v, g.c, g.t, e.v, e.c, e.t);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    res_t e, g;
    int start;
    out_ready = 1'b1;
    start = cyc;
    for (int i = 0; i < 8; i++)
      send_m($urandom, 32'($urandom_range(0, 70)), 12'($urandom), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    drain(8);
    checks++;
    if (cyc - start !== 10) begin
      errors++;
      $display("FAIL back_to_back_cycles: got %0d cycles required 10", cyc - start);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL back_to_back: got v=%h c=%b t=%h required v=%h c=%b t=%h", g.v, g.c, g.t, e.v, e.c, e.t);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random_stream();
    res_t e, g;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      send_m($urandom,
             $urandom_range(0, 1) ? 32'($urandom_range(0, 70)) : 32'($urandom),
             12'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)));
    drain(40);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL random_stream: got v=%h c=%b t=%h required v=%h c=%b t=%h", g.v, g.c, g.t, e.v, e.c, e.t);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_pressure();
    res_t e, g;
    logic [32:0] m;
    logic [31:0] prev_val;
    logic [3:0]  prev_tag;
    logic        prev_c, prev_stall, exp_rdy;
    int          sent, inflight;
    sent = 0;
    prev_stall = 1'b0; prev_val = '0; prev_c = 1'b0; prev_tag = '0;
    m = '0;
    for (int c = 0; c < 40 && got_q.size() < 6; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (sent < 6) begin
        val_rm = $urandom; val_rs = 32'($urandom_range(0, 40)); shift_operand = 12'($urandom);
        immediate = 1'b0; is_mem_command = 1'b0; carry_in = 1'($urandom_range(0, 1));
        tag_in = 4'(sent); in_valid = 1'b1;
        m = model(val_rm, val_rs, shift_operand, immediate, is_mem_command, carry_in);
      end else begin
        in_valid = 1'b0;
      end
      inflight = exp_q.size() - got_q.size();
      exp_rdy = !(inflight == 2 && !out_ready);
      step();
      checks++;
      if (s_in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL bp_in_ready cycle %0d: got %b required %b", c, s_in_ready, exp_rdy);
      end
      if (prev_stall) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_val !== prev_val || s_c !== prev_c || s_tag !== prev_tag) begin
          errors++;
          $display("FAIL bp_stable cycle %0d: got vld=%b v=%h c=%b t=%h required vld=1 v=%h c=%b t=%h",
                   c, s_out_valid, s_val, s_c, s_tag, prev_val, prev_c, prev_tag);
        end
      end
      prev_stall = s_out_valid && !out_ready;
      prev_val = s_val; prev_c = s_c; prev_tag = s_tag;
      if (s_acc) begin
        exp_q.push_back({m[31:0], m[32], 4'(sent)});
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got_q.size() != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d results required 6", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL back_pressure: got v=%h c=%b t=%h required v=%h c=%b t=%h", g.v, g.c, g.t, e.v, e.c, e.t);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    next_tag = 4'hA;
    send_m(32'h11111111, 32'd4, 12'h030, 1'b0, 1'b0, 1'b1);
    send_m(32'h22222222, 32'd4, 12'h010, 1'b0, 1'b0, 1'b1);
    flush = 1'b1; in_valid = 1'b1; tag_in = 4'hC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();
    checks += 2;
    if (s_out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b required 0", s_out_valid); end
    if (s_in_ready !== 1'b1)  begin errors++; $display("FAIL flush_in_ready: got %b required 1", s_in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL flush_leak: got %0d results (first tag %h) required 0", got_q.size(), got_q[0].t);
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_rst_mid_stream();
    out_ready = 1'b0;
    next_tag = 4'h7;
    send_m(32'hFFFFFFFF, 32'd0, 12'h0FF, 1'b1, 1'b0, 1'b1);
    send_m(32'hFFFFFFFF, 32'd0, 12'h0FF, 1'b1, 1'b0, 1'b1);
    step();
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    checks += 5;
    if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b required 0", s_out_valid); end
    if (s_val !== 32'd0)      begin errors++; $display("FAIL rst_mid_val2: got %h required 0", s_val); end
    if (s_c !== 1'b0)         begin errors++; $display("FAIL rst_mid_carry: got %b required 0", s_c); end
    if (s_tag !== 4'd0)       begin errors++; $display("FAIL rst_mid_tag: got %h required 0", s_tag); end
    if (s_in_ready !== 1'b1)  begin errors++; $display("FAIL rst_mid_in_ready: got %b required 1", s_in_ready); end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    val_rm = '0; val_rs = '0; shift_operand = '0;
    immediate = 1'b0; is_mem_command = 1'b0; carry_in = 1'b0; tag_in = '0;
    @(negedge clk);
    test_reset();
    test_imm_rotate();
    test_imm_shift_edges();
    test_reg_shift();
    test_mem_mode();
    test_back_to_back();
    test_random_stream();
    test_back_pressure();
    test_flush();
    test_rst_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
